// File: rtl/bk_add_arbiter_if.sv
// bk_add_arbiter_if: request/response bundle between the adder clients and
// bk_add_arbiter. The requester/consumer side uses the master modport and the
// arbiter uses the slave modport. Requester k's operands sit at bits
// [k*WIDTH +: WIDTH] of req_a/req_b.
interface bk_add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_last;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/bk_add_arbiter.sv
// bk_add_arbiter: shares one external combinational 32-bit adder between NREQ
// requesters with round-robin arbitration and a single registered response
// port with backpressure. Results appear one cycle after the accepting edge.
//
// Optional feature: define BK_ARB_CHAIN_EN to enable multi-word carry chaining.
// An accept with req_last=0 locks the grant onto that requester and feeds the
// stored carry into the adder for its following beats until req_last=1.
// Without the macro req_last is ignored and the FSM never leaves IDLE.
module bk_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  bk_add_arbiter_if.slave  bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t           state;
  state_t           next_state;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;
  logic             ptr_adv;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW:0]     cand;
  logic [IDW:0]     inc;
  logic             can_accept;
  logic             accept;
  logic [NREQ-1:0]  ready_w;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

`ifdef BK_ARB_CHAIN_EN
  logic             chain_carry;
  logic [IDW-1:0]   lock_id;
`else
  logic             unused_last;
  assign unused_last = ^bus.req_last;
`endif

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k] = bus.req_a[k*WIDTH +: WIDTH];
    assign b_arr[k] = bus.req_b[k*WIDTH +: WIDTH];
  end

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign accept     = found && can_accept;

  // Round-robin search starting at ptr with wrap; a lock pins the grant to one id
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
`ifdef BK_ARB_CHAIN_EN
    if (state == LOCK) begin
      found  = bus.req_valid[lock_id];
      winner = bus.req_valid[lock_id] ? lock_id : '0;
    end
`endif
  end

  // One-hot ready for the winner, only when the response slot can take a result
  always_comb begin
    ready_w = '0;
    if (accept) begin
      ready_w[winner] = 1'b1;
    end
  end

  assign bus.req_ready = ready_w;

  // Pointer value just past the winner, wrapping at NREQ
  always_comb begin
    inc = {1'b0, winner} + (IDW+1)'(1);
    if (inc == NREQ_W) begin
      inc = '0;
    end
    ptr_next = inc[IDW-1:0];
  end

  assign add_a = a_arr[winner];
  assign add_b = b_arr[winner];
`ifdef BK_ARB_CHAIN_EN
  assign add_cin = (state == LOCK && found) ? chain_carry : bus.req_cin[winner];
`else
  assign add_cin = bus.req_cin[winner];
`endif

  // Next-state logic; the pointer only moves when an operation completes
  always_comb begin
    next_state = state;
    ptr_adv    = accept;
`ifdef BK_ARB_CHAIN_EN
    case (state)
      IDLE, LOCK: begin
        if (accept) begin
          next_state = bus.req_last[winner] ? IDLE : LOCK;
          ptr_adv    = bus.req_last[winner];
        end
      end
      default: begin
        next_state = IDLE;
        ptr_adv    = 1'b0;
      end
    endcase
`else
    next_state = IDLE;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Response register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      ptr         <= '0;
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= winner;
        rsp_sum_q   <= add_sum;
        rsp_cout_q  <= add_cout;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (ptr_adv) begin
        ptr <= ptr_next;
      end
    end
  end

`ifdef BK_ARB_CHAIN_EN
  // Chain carry and locked id follow every accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_carry <= 1'b0;
      lock_id     <= '0;
    end else if (accept) begin
      chain_carry <= add_cout;
      lock_id     <= winner;
    end
  end
`endif

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_bk_add_arbiter.sv
// tb_bk_add_arbiter: directed scenarios with fixed expected values plus a
// randomized run against a transaction-level reference model of the arbiter.
module tb_bk_add_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
`ifdef BK_ARB_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  int checks = 0;
  int errors = 0;

  logic             drv_valid [NREQ];
  logic [WIDTH-1:0] drv_a [NREQ];
  logic [WIDTH-1:0] drv_b [NREQ];
  logic             drv_cin [NREQ];
  logic             drv_last [NREQ];
  logic             drv_rsp_ready = 1'b1;

  // reference model state
  int           m_ptr;
  bit           m_valid;
  int           m_id;
  logic [WIDTH:0] m_res;
  bit           m_locked;
  int           m_lock_id;
  bit           m_carry;
  int           m_acc;

  bk_add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  bk_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // stand-in for the shared external adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    logic [NREQ-1:0]       v, c, l;
    logic [NREQ*WIDTH-1:0] pa, pb;
    for (int k = 0; k < NREQ; k++) begin
      v[k] = drv_valid[k];
      c[k] = drv_cin[k];
      l[k] = drv_last[k];
      pa[k*WIDTH +: WIDTH] = drv_a[k];
      pb[k*WIDTH +: WIDTH] = drv_b[k];
    end
    bus.req_valid = v;
    bus.req_cin   = c;
    bus.req_last  = l;
    bus.req_a     = pa;
    bus.req_b     = pb;
    bus.rsp_ready = drv_rsp_ready;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NREQ; k++) begin
      drv_valid[k] = 1'b0;
      drv_a[k]     = '0;
      drv_b[k]     = '0;
      drv_cin[k]   = 1'b0;
      drv_last[k]  = 1'b1;
    end
  endtask

  task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic last);
    drv_valid[k] = 1'b1;
    drv_a[k]     = a;
    drv_b[k]     = b;
    drv_cin[k]   = cin;
    drv_last[k]  = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    drv_rsp_ready = 1'b1;
    apply_stimulus();
    tick();
    tick();
    rst_n = 1'b1;
    apply_stimulus();
  endtask

  task automatic new_op(input int k);
    logic [WIDTH-1:0] a, b;
    a = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
    b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
    set_req(k, a, b, 1'($urandom_range(1)), ($urandom_range(2) != 0));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = '0;
    m_locked = 0; m_lock_id = 0; m_carry = 0; m_acc = -1;
  endtask

  // first valid requester in round-robin order, or the locked one
  function automatic int model_winner();
    if (CHAIN && m_locked) return drv_valid[m_lock_id] ? m_lock_id : -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (drv_valid[k]) return k;
    end
    return -1;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int w;
    bit cin;
    logic [WIDTH:0] res;
    w = model_winner();
    m_acc = -1;
    if (w >= 0 && (!m_valid || drv_rsp_ready)) begin
      cin = (CHAIN && m_locked) ? m_carry : drv_cin[w];
      res = {1'b0, drv_a[w]} + {1'b0, drv_b[w]} + (WIDTH+1)'(cin);
      m_valid = 1; m_id = w; m_res = res; m_acc = w; m_carry = res[WIDTH];
      if (CHAIN && !drv_last[w]) begin
        m_locked = 1; m_lock_id = w;
      end else begin
        m_locked = 0; m_ptr = (w + 1) % NREQ;
      end
    end else if (drv_rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, $urandom, $urandom, 1'b1, 1'b1);
    rst_n = 1'b0;
    apply_stimulus();
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum got=%h exp=0", bus.rsp_sum); end
    checks++; if (bus.rsp_cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got=%b exp=0", bus.rsp_cout); end
    rst_n = 1'b1;
    clear_reqs();
    drv_a[0] = 32'h1234_5678;
    drv_b[0] = 32'h0BAD_F00D;
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL idle_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (add_a !== 32'h1234_5678) begin errors++; $display("[TB] FAIL idle_add_a got=%h exp=12345678", add_a); end
    checks++; if (add_b !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL idle_add_b got=%h exp=0badf00d", add_b); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 32'd1024, 32'd1023, 1'b0, 1'b1);
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got=%b exp=0001", bus.req_ready); end
    checks++; if (add_a !== 32'd1024) begin errors++; $display("[TB] FAIL single_add_a got=%0d exp=1024", add_a); end
    tick();
    drv_valid[0] = 1'b0;
    apply_stimulus();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.rsp_sum !== 32'd2047) begin errors++; $display("[TB] FAIL single_sum got=%0d exp=2047", bus.rsp_sum); end
    checks++; if (bus.rsp_cout !== 1'b0) begin errors++; $display("[TB] FAIL single_cout got=%b exp=0", bus.rsp_cout); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_sum !== 32'd2047) begin errors++; $display("[TB] FAIL single_hold_sum got=%0d exp=2047", bus.rsp_sum); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] ta [3];
    logic [WIDTH-1:0] tb [3];
    logic             tc [3];
    logic [WIDTH:0]   te [3];
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;          tc[0] = 1'b0; te[0] = 33'h1_0000_0000;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd0;          tc[1] = 1'b1; te[1] = 33'h1_0000_0000;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF;  tc[2] = 1'b1; te[2] = 33'h1_FFFF_FFFF;
    drv_rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(0, ta[t], tb[t], tc[t], 1'b1);
      apply_stimulus();
      tick();
      drv_valid[0] = 1'b0;
      apply_stimulus();
      checks++;
      if ({bus.rsp_cout, bus.rsp_sum} !== te[t] || bus.rsp_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL overflow_%0d got=%b_%h valid=%b exp=%h", t, bus.rsp_cout, bus.rsp_sum, bus.rsp_valid, te[t]);
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [WIDTH:0] exp_res [NREQ];
    int k;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      set_req(r, $urandom, $urandom, 1'($urandom_range(1)), 1'b1);
      exp_res[r] = {1'b0, drv_a[r]} + {1'b0, drv_b[r]} + (WIDTH+1)'(drv_cin[r]);
    end
    apply_stimulus();
    for (int c = 0; c < 8; c++) begin
      k = c % NREQ;
      #1;
      checks++; if (bus.req_ready !== 4'(1 << k)) begin errors++; $display("[TB] FAIL fair_ready[%0d] got=%b exp=%b", c, bus.req_ready, 4'(1 << k)); end
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k)) begin errors++; $display("[TB] FAIL fair_id[%0d] got=%0d valid=%b exp=%0d", c, bus.rsp_id, bus.rsp_valid, k); end
      checks++; if ({bus.rsp_cout, bus.rsp_sum} !== exp_res[k]) begin errors++; $display("[TB] FAIL fair_sum[%0d] got=%h exp=%h", c, {bus.rsp_cout, bus.rsp_sum}, exp_res[k]); end
      set_req(k, $urandom, $urandom, 1'($urandom_range(1)), 1'b1);
      exp_res[k] = {1'b0, drv_a[k]} + {1'b0, drv_b[k]} + (WIDTH+1)'(drv_cin[k]);
      apply_stimulus();
    end
    clear_reqs();
    apply_stimulus();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 32'd10, 32'd20, 1'b0, 1'b1);
    apply_stimulus();
    tick();
    drv_valid[0] = 1'b0;
    set_req(1, 32'd5, 32'd6, 1'b0, 1'b1);
    set_req(3, 32'd40, 32'd2, 1'b0, 1'b1);
    drv_rsp_ready = 1'b0;
    apply_stimulus();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=0000", c, bus.req_ready); end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 32'd30 || bus.rsp_cout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%b id=%0d sum=%0d cout=%b exp 1/0/30/0", c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
      end
    end
    drv_rsp_ready = 1'b1;
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release_ready got=%b exp=0010", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'd11) begin errors++; $display("[TB] FAIL bp_release_rsp got id=%0d sum=%0d exp id=1 sum=11", bus.rsp_id, bus.rsp_sum); end
    drv_valid[1] = 1'b0;
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL bp_next_ready got=%b exp=1000", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_sum !== 32'd42) begin errors++; $display("[TB] FAIL bp_next_rsp got id=%0d sum=%0d exp id=3 sum=42", bus.rsp_id, bus.rsp_sum); end
    clear_reqs();
    apply_stimulus();
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_req(2, 32'd100, 32'd200, 1'b0, 1'b1);
    apply_stimulus();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'd300) begin errors++; $display("[TB] FAIL mid_pre got valid=%b sum=%0d exp 1/300", bus.rsp_valid, bus.rsp_sum); end
    clear_reqs();
    set_req(1, 32'd3, 32'd4, 1'b0, 1'b1);
    set_req(3, 32'd8, 32'd9, 1'b0, 1'b1);
    drv_rsp_ready = 1'b0;
    rst_n = 1'b0;
    apply_stimulus();
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 32'd0 || bus.rsp_cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got valid=%b id=%0d sum=%0d cout=%b exp all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
    end
    rst_n = 1'b1;
    drv_rsp_ready = 1'b1;
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL mid_grant got=%b exp=0010", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'd7) begin errors++; $display("[TB] FAIL mid_rsp got id=%0d sum=%0d exp id=1 sum=7", bus.rsp_id, bus.rsp_sum); end
    clear_reqs();
    apply_stimulus();
    tick();
  endtask

`ifdef BK_ARB_CHAIN_EN
  task automatic test_chain();
    do_reset();
    set_req(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    set_req(2, 32'd7, 32'd8, 1'b0, 1'b1);
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL chain_b1_ready got=%b exp=0010", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'd0 || bus.rsp_cout !== 1'b1) begin errors++; $display("[TB] FAIL chain_b1_rsp got id=%0d sum=%h cout=%b exp 1/0/1", bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
    set_req(1, 32'd0, 32'd0, 1'b0, 1'b1);
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL chain_b2_ready got=%b exp=0010", bus.req_ready); end
    checks++; if (add_cin !== 1'b1) begin errors++; $display("[TB] FAIL chain_b2_cin got=%b exp=1", add_cin); end
    tick();
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'd1 || bus.rsp_cout !== 1'b0) begin errors++; $display("[TB] FAIL chain_b2_rsp got id=%0d sum=%h cout=%b exp 1/1/0", bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
    drv_valid[1] = 1'b0;
    apply_stimulus();
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL chain_after_ready got=%b exp=0100", bus.req_ready); end
    tick();
    checks++; if (bus.rsp_id !== 2'd2 || bus.rsp_sum !== 32'd15) begin errors++; $display("[TB] FAIL chain_after_rsp got id=%0d sum=%0d exp id=2 sum=15", bus.rsp_id, bus.rsp_sum); end
    clear_reqs();
    apply_stimulus();
    tick();
  endtask
`endif

  task automatic test_random();
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_cin;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_acc == k) begin
          if ($urandom_range(3) != 0) new_op(k);
          else drv_valid[k] = 1'b0;
        end else if (!drv_valid[k] && $urandom_range(1) == 1) begin
          new_op(k);
        end
      end
      drv_rsp_ready = ($urandom_range(3) != 0);
      apply_stimulus();
      #1;
      w = model_winner();
      exp_rdy = '0;
      if (w >= 0 && (!m_valid || drv_rsp_ready)) exp_rdy[w] = 1'b1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rand_ready[%0d] got=%b exp=%b", c, bus.req_ready, exp_rdy); end
      if (w >= 0) begin
        exp_cin = (CHAIN && m_locked) ? m_carry : drv_cin[w];
        checks++;
        if (add_a !== drv_a[w] || add_b !== drv_b[w] || add_cin !== exp_cin) begin
          errors++;
          $display("[TB] FAIL rand_adder[%0d] got a=%h b=%h cin=%b exp a=%h b=%h cin=%b", c, add_a, add_b, add_cin, drv_a[w], drv_b[w], exp_cin);
        end
      end
      tick();
      model_edge();
      checks++; if (bus.rsp_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d] got=%b exp=%b", c, bus.rsp_valid, m_valid); end
      checks++; if (bus.rsp_id !== IDW'(m_id)) begin errors++; $display("[TB] FAIL rand_id[%0d] got=%0d exp=%0d", c, bus.rsp_id, m_id); end
      checks++; if ({bus.rsp_cout, bus.rsp_sum} !== m_res) begin errors++; $display("[TB] FAIL rand_sum[%0d] got=%h exp=%h", c, {bus.rsp_cout, bus.rsp_sum}, m_res); end
    end
    clear_reqs();
    drv_rsp_ready = 1'b1;
    apply_stimulus();
    tick();
  endtask

  initial begin
    clear_reqs();
    $display("[TB] starting bk_add_arbiter bench (chain=%0d)", CHAIN);
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_midstream();
`ifdef BK_ARB_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
